dbus_arbiter: RTL and testbench

- Shares the single memory-mapped data bus (RAM, switches/buttons, LED register, UART A, UART B) between two masters.
- Master 0 is the picorv32 data port; master 1 is a loader/DMA engine.
- Round-robin arbitration, one transfer in flight at a time.
- Decodes the address, drives RAM enable, and returns latched read data with a fixed response latency, replacing the free-running combinational read mux.

---
 rtl/dbus_pkg.sv | 18 +
 rtl/dbus_arbiter_if.sv | 31 +++
 rtl/dbus_decode.sv | 24 ++
 rtl/dbus_arbiter.sv | 126 ++++++++++++
 tb/tb_dbus_arbiter.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/dbus_pkg.sv
// Shared types and address map for the two-master data-bus arbiter.
package dbus_pkg;

   typedef enum logic [1:0] {IDLE, ADDR, WAIT, RESP} state_t;

   typedef enum logic [2:0] {T_SW, T_LED, T_UARTA, T_UARTB, T_RAM, T_NONE} tgt_t;

   localparam logic [31:0] ADDR_SW       = 32'h0000_2000;
   localparam logic [31:0] ADDR_LED      = 32'h0000_2004;
   localparam logic [31:0] ADDR_UARTA_0  = 32'h0000_2010;
   localparam logic [31:0] ADDR_UARTA_1  = 32'h0000_2018;
   localparam logic [31:0] ADDR_UARTA_2  = 32'h0000_201C;
   localparam logic [31:0] ADDR_UARTB_0  = 32'h0000_2020;
   localparam logic [31:0] ADDR_UARTB_1  = 32'h0000_2028;
   localparam logic [31:0] ADDR_UARTB_2  = 32'h0000_202C;
   localparam logic [31:0] RAM_BASE      = 32'h0004_0000;

endpackage

// File: rtl/dbus_arbiter_if.sv
// Bundle of master request/response, shared bus and peripheral read-data signals.
// master = masters and peripherals side, slave = the arbiter.
interface dbus_arbiter_if;

   logic        m0_req, m0_we, m0_gnt, m0_rvalid;
   logic [31:0] m0_addr, m0_wdata, m0_rdata;
   logic        m1_req, m1_we, m1_gnt, m1_rvalid;
   logic [31:0] m1_addr, m1_wdata, m1_rdata;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_we, ram_en, bus_err;
   logic [31:0] sw_rdata, uarta_rdata, uartb_rdata, ram_rdata;

   modport master (
      output m0_req, m0_we, m0_addr, m0_wdata,
      output m1_req, m1_we, m1_addr, m1_wdata,
      output sw_rdata, uarta_rdata, uartb_rdata, ram_rdata,
      input  m0_gnt, m0_rvalid, m0_rdata,
      input  m1_gnt, m1_rvalid, m1_rdata,
      input  bus_addr, bus_wdata, bus_we, ram_en, bus_err
   );

   modport slave (
      input  m0_req, m0_we, m0_addr, m0_wdata,
      input  m1_req, m1_we, m1_addr, m1_wdata,
      input  sw_rdata, uarta_rdata, uartb_rdata, ram_rdata,
      output m0_gnt, m0_rvalid, m0_rdata,
      output m1_gnt, m1_rvalid, m1_rdata,
      output bus_addr, bus_wdata, bus_we, ram_en, bus_err
   );

endinterface

// File: rtl/dbus_decode.sv
// Combinational byte-address to peripheral-target decoder.
module dbus_decode
   import dbus_pkg::*;
(
   input  logic [31:0] addr_i,
   output tgt_t        tgt_o
);

   always_comb begin
      tgt_o = T_NONE;
      if (addr_i >= RAM_BASE) begin
         tgt_o = T_RAM;
      end else begin
         case (addr_i)
            ADDR_SW:                                 tgt_o = T_SW;
            ADDR_LED:                                tgt_o = T_LED;
            ADDR_UARTA_0, ADDR_UARTA_1, ADDR_UARTA_2: tgt_o = T_UARTA;
            ADDR_UARTB_0, ADDR_UARTB_1, ADDR_UARTB_2: tgt_o = T_UARTB;
            default:                                 tgt_o = T_NONE;
         endcase
      end
   end

endmodule

// File: rtl/dbus_arbiter.sv
// Round-robin two-master arbiter for the shared data bus; one transfer in flight,
// registered strobes and latched read data returned RD_LATENCY+1 cycles after gnt.
module dbus_arbiter
   import dbus_pkg::*;
#(
   parameter int          RD_LATENCY     = 1,
   parameter logic [31:0] UNMAPPED_RDATA = 32'h0000_0000
)(
   input  logic         clk,
   input  logic         reset,
   dbus_arbiter_if.slave bus
);

   localparam logic [1:0] CNT_LOAD = 2'(RD_LATENCY - 1);

   state_t      state_q;
   logic        id_q, we_q, ptr_q;
   logic [31:0] addr_q, wdata_q;
   logic [1:0]  cnt_q;
   logic [1:0]  gnt_q, rvalid_q;
   logic [31:0] rdata0_q, rdata1_q;
   logic        bus_we_q, ram_en_q, bus_err_q;

   logic        any_req, win, win_we;
   logic [31:0] win_addr, win_wdata, rdata_d;
   tgt_t        nxt_tgt, cur_tgt;

   // The pointer only matters when both masters request in the same cycle.
   assign any_req   = bus.m0_req | bus.m1_req;
   assign win       = (bus.m0_req & bus.m1_req) ? ptr_q : bus.m1_req;
   assign win_we    = win ? bus.m1_we    : bus.m0_we;
   assign win_addr  = win ? bus.m1_addr  : bus.m0_addr;
   assign win_wdata = win ? bus.m1_wdata : bus.m0_wdata;

   // Strobes for the address phase are registered, so decode the incoming winner too.
   dbus_decode u_dec_nxt (.addr_i(win_addr), .tgt_o(nxt_tgt));
   dbus_decode u_dec_cur (.addr_i(addr_q),   .tgt_o(cur_tgt));

   always_comb begin
      rdata_d = UNMAPPED_RDATA;
      case (cur_tgt)
         T_SW:    rdata_d = bus.sw_rdata;
         T_UARTA: rdata_d = bus.uarta_rdata;
         T_UARTB: rdata_d = bus.uartb_rdata;
         T_RAM:   rdata_d = bus.ram_rdata;
         default: rdata_d = UNMAPPED_RDATA;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         id_q      <= 1'b0;
         we_q      <= 1'b0;
         ptr_q     <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         cnt_q     <= '0;
         gnt_q     <= '0;
         rvalid_q  <= '0;
         rdata0_q  <= '0;
         rdata1_q  <= '0;
         bus_we_q  <= 1'b0;
         ram_en_q  <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         gnt_q     <= '0;
         rvalid_q  <= '0;
         bus_we_q  <= 1'b0;
         ram_en_q  <= 1'b0;
         bus_err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  id_q       <= win;
                  we_q       <= win_we;
                  addr_q     <= win_addr;
                  wdata_q    <= win_wdata;
                  gnt_q[win] <= 1'b1;
                  bus_we_q   <= win_we && (nxt_tgt != T_NONE);
                  ram_en_q   <= win_addr[18];
                  bus_err_q  <= (nxt_tgt == T_NONE);
                  state_q    <= ADDR;
               end
            end
            ADDR: begin
               if (we_q) begin
                  ptr_q   <= ~id_q;
                  state_q <= IDLE;
               end else begin
                  cnt_q   <= CNT_LOAD;
                  state_q <= WAIT;
               end
            end
            WAIT: begin
               if (cnt_q == 2'd0) begin
                  if (id_q) rdata1_q <= rdata_d;
                  else      rdata0_q <= rdata_d;
                  rvalid_q[id_q] <= 1'b1;
                  state_q        <= RESP;
               end else begin
                  cnt_q <= cnt_q - 2'd1;
               end
            end
            RESP: begin
               ptr_q   <= ~id_q;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign bus.m0_gnt    = gnt_q[0];
   assign bus.m1_gnt    = gnt_q[1];
   assign bus.m0_rvalid = rvalid_q[0];
   assign bus.m1_rvalid = rvalid_q[1];
   assign bus.m0_rdata  = rdata0_q;
   assign bus.m1_rdata  = rdata1_q;
   assign bus.bus_addr  = addr_q;
   assign bus.bus_wdata = wdata_q;
   assign bus.bus_we    = bus_we_q;
   assign bus.ram_en    = ram_en_q;
   assign bus.bus_err   = bus_err_q;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Directed bench: one arbiter with RD_LATENCY=1, a second with RD_LATENCY=3.
module tb_dbus_arbiter;

   logic clk;
   logic reset;
   int   n_cmp;
   int   n_err;

   dbus_arbiter_if bi1 ();
   dbus_arbiter_if bi3 ();

   dbus_arbiter #(.RD_LATENCY(1), .UNMAPPED_RDATA(32'h0000_0000)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (bi1)
   );

   dbus_arbiter #(.RD_LATENCY(3), .UNMAPPED_RDATA(32'h0000_0000)) dut3 (
      .clk   (clk),
      .reset (reset),
      .bus   (bi3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      reset = 1'b1;
      {bi1.m0_req, bi1.m0_we, bi1.m1_req, bi1.m1_we} = '0;
      {bi1.m0_addr, bi1.m0_wdata, bi1.m1_addr, bi1.m1_wdata} = '0;
      {bi1.sw_rdata, bi1.uarta_rdata, bi1.uartb_rdata, bi1.ram_rdata} = '0;
      {bi3.m0_req, bi3.m0_we, bi3.m1_req, bi3.m1_we} = '0;
      {bi3.m0_addr, bi3.m0_wdata, bi3.m1_addr, bi3.m1_wdata} = '0;
      {bi3.sw_rdata, bi3.uarta_rdata, bi3.uartb_rdata, bi3.ram_rdata} = '0;

      // Reset state
      tick();
      tick();
      chk("rst_gnt",   {30'd0, bi1.m1_gnt, bi1.m0_gnt}, 32'd0);
      chk("rst_rv",    {30'd0, bi1.m1_rvalid, bi1.m0_rvalid}, 32'd0);
      chk("rst_strb",  {29'd0, bi1.bus_we, bi1.ram_en, bi1.bus_err}, 32'd0);
      chk("rst_addr",  bi1.bus_addr, 32'd0);
      chk("rst_rdata", bi1.m0_rdata, 32'd0);
      reset = 1'b0;
      tick();

      // Single write by m0 to the LED register
      bi1.m0_req = 1'b1; bi1.m0_we = 1'b1;
      bi1.m0_addr = 32'h0000_2004; bi1.m0_wdata = 32'h0000_00A5;
      tick();
      chk("wr_gnt0",  {31'd0, bi1.m0_gnt}, 32'd1);
      chk("wr_gnt1",  {31'd0, bi1.m1_gnt}, 32'd0);
      chk("wr_we",    {31'd0, bi1.bus_we}, 32'd1);
      chk("wr_addr",  bi1.bus_addr, 32'h0000_2004);
      chk("wr_wdata", bi1.bus_wdata, 32'h0000_00A5);
      chk("wr_err",   {31'd0, bi1.bus_err}, 32'd0);
      bi1.m0_req = 1'b0;
      tick();
      chk("wr_we_off",  {31'd0, bi1.bus_we}, 32'd0);
      chk("wr_gnt_off", {31'd0, bi1.m0_gnt}, 32'd0);
      tick();
      chk("wr_no_rv",   {31'd0, bi1.m0_rvalid}, 32'd0);

      // RAM read by m1
      bi1.ram_rdata = 32'h1234_5678;
      bi1.m1_req = 1'b1; bi1.m1_we = 1'b0; bi1.m1_addr = 32'h0004_0010;
      tick();
      chk("ram_gnt1", {31'd0, bi1.m1_gnt}, 32'd1);
      chk("ram_en",   {31'd0, bi1.ram_en}, 32'd1);
      chk("ram_we",   {31'd0, bi1.bus_we}, 32'd0);
      chk("ram_addr", bi1.bus_addr, 32'h0004_0010);
      bi1.m1_req = 1'b0;
      tick();
      chk("ram_wait_rv", {31'd0, bi1.m1_rvalid}, 32'd0);
      chk("ram_wait_en", {31'd0, bi1.ram_en}, 32'd0);
      tick();
      chk("ram_rv1",   {31'd0, bi1.m1_rvalid}, 32'd1);
      chk("ram_rv0",   {31'd0, bi1.m0_rvalid}, 32'd0);
      chk("ram_rdata", bi1.m1_rdata, 32'h1234_5678);
      tick();
      chk("ram_rv_off", {31'd0, bi1.m1_rvalid}, 32'd0);

      // Contention: both masters keep reading the switches
      bi1.sw_rdata = 32'h0000_F00F;
      bi1.m0_req = 1'b1; bi1.m0_we = 1'b0; bi1.m0_addr = 32'h0000_2000;
      bi1.m1_req = 1'b1; bi1.m1_we = 1'b0; bi1.m1_addr = 32'h0000_2000;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rr_gnt%0d", k), {30'd0, bi1.m1_gnt, bi1.m0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd2);
         tick();
         tick();
         chk($sformatf("rr_rv%0d", k), {30'd0, bi1.m1_rvalid, bi1.m0_rvalid}, (k % 2 == 0) ? 32'd1 : 32'd2);
         chk($sformatf("rr_dat%0d", k), (k % 2 == 0) ? bi1.m0_rdata : bi1.m1_rdata, 32'h0000_F00F);
         if (k == 3) begin
            bi1.m0_req = 1'b0;
            bi1.m1_req = 1'b0;
         end
         tick();
      end

      // Unmapped write then read by m0
      bi1.m0_req = 1'b1; bi1.m0_we = 1'b1; bi1.m0_addr = 32'h0000_3000; bi1.m0_wdata = 32'h55;
      tick();
      chk("um_wr_gnt", {31'd0, bi1.m0_gnt}, 32'd1);
      chk("um_wr_err", {31'd0, bi1.bus_err}, 32'd1);
      chk("um_wr_we",  {31'd0, bi1.bus_we}, 32'd0);
      bi1.m0_req = 1'b0;
      tick();
      chk("um_err_off", {31'd0, bi1.bus_err}, 32'd0);
      bi1.m0_req = 1'b1; bi1.m0_we = 1'b0;
      tick();
      chk("um_rd_err", {31'd0, bi1.bus_err}, 32'd1);
      bi1.m0_req = 1'b0;
      tick();
      tick();
      chk("um_rd_rv",    {31'd0, bi1.m0_rvalid}, 32'd1);
      chk("um_rd_rdata", bi1.m0_rdata, 32'd0);
      tick();

      // LED read: returns unmapped data without an error
      bi1.m1_req = 1'b1; bi1.m1_we = 1'b0; bi1.m1_addr = 32'h0000_2004;
      tick();
      chk("led_gnt", {31'd0, bi1.m1_gnt}, 32'd1);
      chk("led_err", {31'd0, bi1.bus_err}, 32'd0);
      bi1.m1_req = 1'b0;
      tick();
      tick();
      chk("led_rv",    {31'd0, bi1.m1_rvalid}, 32'd1);
      chk("led_rdata", bi1.m1_rdata, 32'd0);
      tick();

      // m0 write leaves the pointer on m1; then reset during an m1 RAM read's WAIT
      bi1.m0_req = 1'b1; bi1.m0_we = 1'b1; bi1.m0_addr = 32'h0000_2004;
      tick();
      bi1.m0_req = 1'b0;
      tick();
      bi1.m1_req = 1'b1; bi1.m1_we = 1'b0; bi1.m1_addr = 32'h0004_0020;
      tick();
      chk("rw_gnt1", {31'd0, bi1.m1_gnt}, 32'd1);
      bi1.m1_req = 1'b0;
      tick();
      #2;
      reset = 1'b1;
      #1;
      chk("rw_addr0",  bi1.bus_addr, 32'd0);
      chk("rw_rdata0", bi1.m1_rdata, 32'd0);
      chk("rw_strb0",  {28'd0, bi1.m1_gnt, bi1.m1_rvalid, bi1.ram_en, bi1.bus_we}, 32'd0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("rw_no_rv%0d", k), {30'd0, bi1.m1_rvalid, bi1.m0_rvalid}, 32'd0);
      end
      bi1.m0_req = 1'b1; bi1.m0_we = 1'b0; bi1.m0_addr = 32'h0000_2000;
      bi1.m1_req = 1'b1; bi1.m1_we = 1'b0; bi1.m1_addr = 32'h0000_2000;
      tick();
      chk("rw_ptr_gnt", {30'd0, bi1.m1_gnt, bi1.m0_gnt}, 32'd1);
      bi1.m0_req = 1'b0;
      bi1.m1_req = 1'b0;
      tick();
      tick();
      chk("rw_rv0",    {31'd0, bi1.m0_rvalid}, 32'd1);
      chk("rw_rdata",  bi1.m0_rdata, 32'h0000_F00F);
      tick();

      // Latency sweep on the RD_LATENCY=3 instance: UART A read
      bi3.uarta_rdata = 32'hCAFE_BABE;
      bi3.m0_req = 1'b1; bi3.m0_we = 1'b0; bi3.m0_addr = 32'h0000_201C;
      tick();
      chk("lat_gnt", {31'd0, bi3.m0_gnt}, 32'd1);
      bi3.m0_req = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk($sformatf("lat_rv%0d", k), {31'd0, bi3.m0_rvalid}, (k == 4) ? 32'd1 : 32'd0);
      end
      chk("lat_rdata", bi3.m0_rdata, 32'hCAFE_BABE);
      tick();
      chk("lat_rv_off", {31'd0, bi3.m0_rvalid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
